// File: rtl/mips_bp_pkg.sv
// ============================================================================
// Module      : mips_bp_pkg
// Description : Shared types and helpers for the MIPS branch predictor slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    // BTB write-port operation; TRAIN/INV resolve hit/miss inside the array.
    typedef enum logic [1:0] {
        WOP_NONE  = 2'b00,
        WOP_WRITE = 2'b01,
        WOP_TRAIN = 2'b10,
        WOP_INV   = 2'b11
    } bp_wop_t;

    localparam int c_idx_lsb = 2;

    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int tag_lsb(input int entries);
        return c_idx_lsb + $clog2(entries);
    endfunction

    function automatic bp_ctr_t ctr_next(input bp_ctr_t ctr, input logic taken);
        bp_ctr_t nxt;
        nxt = ctr;
        case (ctr)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_branch_predictor_if.sv
// ============================================================================
// Module      : mips_branch_predictor_if
// Description : Fetch lookup, EX resolve and statistics bundle of the predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_branch_predictor_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic [PC_W-1:0]  f_pc;
    logic             f_pred_taken;
    logic [PC_W-1:0]  f_next_pc;
    logic             ex_valid;
    logic [PC_W-1:0]  ex_pc;
    logic             ex_is_branch;
    logic             ex_is_jump;
    logic             ex_taken;
    logic [PC_W-1:0]  ex_target;
    logic             ex_pred_taken;
    logic [PC_W-1:0]  ex_pred_target;
    logic             ex_mispredict;
    logic [PC_W-1:0]  ex_redirect_pc;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispredicts;

    modport master (
        output f_pc, ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_taken,
               ex_target, ex_pred_taken, ex_pred_target,
        input  f_pred_taken, f_next_pc, ex_mispredict, ex_redirect_pc,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  f_pc, ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_taken,
               ex_target, ex_pred_taken, ex_pred_target,
        output f_pred_taken, f_next_pc, ex_mispredict, ex_redirect_pc,
               stat_branches, stat_mispredicts
    );
endinterface

`default_nettype wire

// File: rtl/mips_btb_ram.sv
// ============================================================================
// Module      : mips_btb_ram
// Description : Direct-mapped BTB array: async read, sync write, async clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_btb_ram
    import mips_bp_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic [$clog2(ENTRIES)-1:0] rd_idx,
    output logic                            rd_valid,
    output logic [TAG_W-1:0]                rd_tag,
    output logic [PC_W-1:0]                 rd_target,
    output logic                            rd_pred,
    input  bp_wop_t                         wr_op,
    input  wire logic [$clog2(ENTRIES)-1:0] wr_idx,
    input  wire logic [TAG_W-1:0]           wr_tag,
    input  wire logic [PC_W-1:0]            wr_target,
    input  wire logic                       wr_taken,
    input  bp_ctr_t                         wr_ctr
);

    logic                r_valid  [ENTRIES];
    bp_ctr_t             r_ctr    [ENTRIES];
    logic [TAG_W-1:0]    r_tag    [ENTRIES];
    logic [PC_W-1:0]     r_target [ENTRIES];
    logic                w_wr_hit;

    assign rd_valid  = r_valid[rd_idx];
    assign rd_tag    = r_tag[rd_idx];
    assign rd_target = r_target[rd_idx];
    assign rd_pred   = r_ctr[rd_idx][1];

    assign w_wr_hit  = r_valid[wr_idx] && (r_tag[wr_idx] == wr_tag);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= WNT;
            end
        end else begin
            case (wr_op)
                WOP_WRITE: begin
                    r_valid[wr_idx] <= 1'b1;
                    r_ctr[wr_idx]   <= wr_ctr;
                end
                WOP_TRAIN: begin
                    if (w_wr_hit) begin
                        r_ctr[wr_idx] <= ctr_next(r_ctr[wr_idx], wr_taken);
                    end else if (wr_taken) begin
                        r_valid[wr_idx] <= 1'b1;
                        r_ctr[wr_idx]   <= WT;
                    end
                end
                WOP_INV: begin
                    if (w_wr_hit) begin
                        r_valid[wr_idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload needs no reset: it is only observed behind a set valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            if ((wr_op == WOP_WRITE) || ((wr_op == WOP_TRAIN) && wr_taken)) begin
                r_tag[wr_idx]    <= wr_tag;
                r_target[wr_idx] <= wr_target;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mips_branch_predictor.sv
// ============================================================================
// Module      : mips_branch_predictor
// Description : BTB-based beq/bne/j predictor with EX training and statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_branch_predictor
    import mips_bp_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 16
) (
    input  wire logic               clk,
    input  wire logic               reset,
    mips_branch_predictor_if.slave  bp
);

    localparam int              c_idx_w   = idx_w(ENTRIES);
    localparam int              c_tag_lsb = tag_lsb(ENTRIES);
    localparam int              c_tag_msb = c_tag_lsb + TAG_W - 1;
    localparam logic [PC_W-1:0] c_pc_step = PC_W'(4);

    logic [c_idx_w-1:0] w_f_idx;
    logic [c_idx_w-1:0] w_ex_idx;
    logic [TAG_W-1:0]   w_f_tag;
    logic [TAG_W-1:0]   w_ex_tag;
    logic               w_rd_valid;
    logic [TAG_W-1:0]   w_rd_tag;
    logic [PC_W-1:0]    w_rd_target;
    logic               w_rd_pred;
    logic               w_hit;
    logic               w_rc;
    logic               w_act_taken;
    logic [PC_W-1:0]    w_act_next;
    logic               w_mispredict;
    bp_wop_t            w_wr_op;
    logic [CNT_W-1:0]   r_stat_branches;
    logic [CNT_W-1:0]   r_stat_mispredicts;

    assign w_f_idx  = bp.f_pc[c_tag_lsb-1:c_idx_lsb];
    assign w_f_tag  = bp.f_pc[c_tag_msb:c_tag_lsb];
    assign w_ex_idx = bp.ex_pc[c_tag_lsb-1:c_idx_lsb];
    assign w_ex_tag = bp.ex_pc[c_tag_msb:c_tag_lsb];

    // Lookup is purely combinational and sees the array before this cycle's write.
    assign w_hit           = reset && w_rd_valid && (w_rd_tag == w_f_tag);
    assign bp.f_pred_taken = w_hit && w_rd_pred;
    assign bp.f_next_pc    = bp.f_pred_taken ? w_rd_target : (bp.f_pc + c_pc_step);

    assign w_rc        = bp.ex_valid && (bp.ex_is_branch || bp.ex_is_jump);
    assign w_act_taken = bp.ex_is_jump || bp.ex_taken;
    assign w_act_next  = w_act_taken ? bp.ex_target : (bp.ex_pc + c_pc_step);

    always_comb begin
        w_mispredict = 1'b0;
        if (w_rc) begin
            w_mispredict = (bp.ex_pred_taken != w_act_taken) ||
                           (w_act_taken && (bp.ex_pred_target != bp.ex_target));
        end else if (bp.ex_valid) begin
            // A predicted-taken non-branch means the BTB entry aliases this PC.
            w_mispredict = bp.ex_pred_taken;
        end
    end

    assign bp.ex_mispredict  = w_mispredict;
    assign bp.ex_redirect_pc = w_act_next;

    always_comb begin
        w_wr_op = WOP_NONE;
        if (bp.ex_valid) begin
            if (bp.ex_is_jump)         w_wr_op = WOP_WRITE;
            else if (bp.ex_is_branch)  w_wr_op = WOP_TRAIN;
            else if (bp.ex_pred_taken) w_wr_op = WOP_INV;
        end
    end

    mips_btb_ram #(
        .PC_W    (PC_W),
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (w_f_idx),
        .rd_valid  (w_rd_valid),
        .rd_tag    (w_rd_tag),
        .rd_target (w_rd_target),
        .rd_pred   (w_rd_pred),
        .wr_op     (w_wr_op),
        .wr_idx    (w_ex_idx),
        .wr_tag    (w_ex_tag),
        .wr_target (bp.ex_target),
        .wr_taken  (bp.ex_taken),
        .wr_ctr    (ST)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (w_rc && (r_stat_branches != '1)) begin
                r_stat_branches <= r_stat_branches + CNT_W'(1);
            end
            if (w_mispredict && (r_stat_mispredicts != '1)) begin
                r_stat_mispredicts <= r_stat_mispredicts + CNT_W'(1);
            end
        end
    end

    assign bp.stat_branches    = r_stat_branches;
    assign bp.stat_mispredicts = r_stat_mispredicts;

endmodule

`default_nettype wire

// File: doc/mips_branch_predictor.md
Name: mips_branch_predictor

Overview:
- Parametrised branch/jump prediction unit for the pipelined successor of single_cycle_cpu.
- Sits beside the IRAM fetch stage and predicts next PC for beq/bne/j from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Resolved outcomes from EX train it and raise a redirect on misprediction.
- Keeps saturating branch and mispredict counters for bench self-checks.

Parameters:
PC_W, 32, PC/target width
ENTRIES, 16, BTB entries; power of 2, >=2; IDX_W = log2(ENTRIES)
TAG_W, 8, tag bits stored per entry
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
f_pc  in  PC_W  fetch PC
f_pred_taken  out  1  prediction for f_pc (combinational)
f_next_pc  out  PC_W  f_pred_taken ? stored target : f_pc+4
ex_valid  in  1  EX-stage instruction valid
ex_pc  in  PC_W  PC of EX instruction
ex_is_branch  in  1  conditional branch (beq/bne)
ex_is_jump  in  1  unconditional j
ex_taken  in  1  resolved direction (ignored for jump, treated as 1)
ex_target  in  PC_W  resolved target
ex_pred_taken  in  1  prediction carried down pipe
ex_pred_target  in  PC_W  predicted next PC carried down pipe
ex_mispredict  out  1  redirect required (combinational)
ex_redirect_pc  out  PC_W  correct next PC
stat_branches  out  CNT_W  resolved branch+jump count
stat_mispredicts  out  CNT_W  mispredict count

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[TAG_W+IDX_W+1:IDX_W+2]. Bits [1:0] are ignored.
- Entry = {valid, tag, target[PC_W], ctr[2]}.
- Reset (async, reset=0): every valid bit is cleared, every ctr is set to WNT (01), and both stats are set to 0. This takes effect immediately, even mid-update.
  - Outputs during reset: f_pred_taken=0, f_next_pc=f_pc+4.
- Lookup (0 latency): hit = valid & tag match. f_pred_taken = hit & ctr[1].
- Same-cycle lookup and update to the same index: lookup sees pre-update contents. There is no bypass.
- Resolved control (rc) = ex_valid & (ex_is_branch | ex_is_jump). If both type flags are set, the instruction is treated as a jump.
- Actual direction: act_taken = ex_is_jump | ex_taken.
- Actual next PC: act_next = act_taken ? ex_target : ex_pc+4. All +4 arithmetic is mod 2^PC_W and wraps silently.
- Mispredict:
  - For rc: ex_mispredict = (ex_pred_taken != act_taken) | (act_taken & ex_pred_target != ex_target).
  - For ex_valid & !rc & ex_pred_taken (alias hit): ex_mispredict=1.
  - ex_redirect_pc = act_next in both cases.
  - ex_valid=0: ex_mispredict=0 and there is no state change.
- Update on the clock edge, rc only:
  - Jump: entry written valid=1, tag, target=ex_target, ctr=ST.
  - Branch hit: ctr saturating ±1 (SNT<->ST) per ex_taken. Target is rewritten only when ex_taken.
  - Branch miss, taken: allocate (overwrite) with ctr=WT, target=ex_target.
  - Branch miss, not-taken: no write.
- Alias invalidate: ex_valid & !rc & ex_pred_taken, with the entry at ex_pc's index tag-matching, clears valid.
- Stats:
  - stat_branches increments on every rc.
  - stat_mispredicts increments when ex_mispredict=1.
  - Both saturate at all-ones and do not wrap.
- The block never stalls. Handshake is the single-cycle ex_valid qualifier only.

Decomposition:
- Package mips_bp_pkg holds:
  - enum bp_ctr_t {SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11}
  - function ctr_next(ctr, taken)
  - localparams for index/tag slicing as functions of ENTRIES/TAG_W
- One sub-module: mips_btb_ram. It holds the ENTRIES-deep async-read, sync-write, async-clear array with one read port and one write/invalidate port.
- Mispredict logic and stats stay in the top module.

Test Plan:
- Reset, then f_pc=0x00000010 -> f_pred_taken=0, f_next_pc=0x00000014, both stats 0.
- j at ex_pc=0x00000028, target 0x00000030 resolved with ex_pred_taken=0 -> ex_mispredict=1, redirect 0x00000030. Next cycle f_pc=0x28 predicts taken, f_next_pc=0x30, stats 1/1.
- beq at 0x10 -> 0x20 resolved taken twice, then not-taken once:
  - ctr goes WT->ST->WT.
  - Lookup of 0x10 still predicts taken.
  - The not-taken resolve with ex_pred_taken=1 redirects to 0x14; stat_mispredicts increments.
- Alias: entry at 0x10 valid; ex_valid, non-branch at 0x10 with ex_pred_taken=1 -> mispredict, redirect 0x14, entry invalidated, next lookup not-taken.
- Same-cycle update and lookup of an empty index with a taken beq -> lookup returns not-taken that cycle, taken the next cycle. Also assert reset mid-sequence -> all entries invalid immediately, stats 0.
- Stats saturation with CNT_W=2: 5 mispredicted jumps -> stat_branches=3, stat_mispredicts=3. Also ex_pc=0xFFFFFFFC not-taken beq -> redirect 0x00000000.
